// File: rtl/multicycle_main_control_if.sv
// Control bundle between the multicycle main control FSM and the datapath.
// IllegalInstr exists only when CTRL_ILLEGAL_TRAP_EN is defined.
interface multicycle_main_control_if;
    logic       Start;
    logic [6:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       AdrSrc;
    logic       MemReq;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       PCWrite;
    logic       InstrDone;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       IllegalInstr;
`endif

    modport master (
        input  Start, Opcode, Zero, MemReady,
        output ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, MemReq, IRWrite,
               MemWrite, RegWrite, PCWrite, InstrDone
`ifdef CTRL_ILLEGAL_TRAP_EN
        , output IllegalInstr
`endif
    );

    modport slave (
        output Start, Opcode, Zero, MemReady,
        input  ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, MemReq, IRWrite,
               MemWrite, RegWrite, PCWrite, InstrDone
`ifdef CTRL_ILLEGAL_TRAP_EN
        , input IllegalInstr
`endif
    );
endinterface

// File: rtl/multicycle_main_control.sv
// Multicycle RISC-V main control FSM with memory-ready stalls.
// Define CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes instead of retiring them as NOPs.
module multicycle_main_control #(
    parameter bit RESET_STATE_FETCH = 1'b1
) (
    input logic                       clk,
    input logic                       rst_n,
    multicycle_main_control_if.master ctrl
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StMemAdr   = 4'd3,
        StMemRead  = 4'd4,
        StMemWrite = 4'd5,
        StMemWb    = 4'd6,
        StExecR    = 4'd7,
        StExecI    = 4'd8,
        StAluWb    = 4'd9,
        StBeq      = 4'd10,
        StJal      = 4'd11,
        StTrap     = 4'd12
    } state_e;

    localparam state_e ResetState = RESET_STATE_FETCH ? StFetch : StIdle;

    state_e r_state;
    state_e w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ResetState;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next              = r_state;
        ctrl.ALUOp          = 2'b00;
        ctrl.ALUSrcA        = 2'b00;
        ctrl.ALUSrcB        = 2'b00;
        ctrl.ResultSrc      = 2'b00;
        ctrl.AdrSrc         = 1'b0;
        ctrl.MemReq         = 1'b0;
        ctrl.IRWrite        = 1'b0;
        ctrl.MemWrite       = 1'b0;
        ctrl.RegWrite       = 1'b0;
        ctrl.PCWrite        = 1'b0;
        ctrl.InstrDone      = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        ctrl.IllegalInstr   = 1'b0;
`endif

        case (r_state)
            StIdle: begin
                if (ctrl.Start) w_next = StFetch;
            end
            StFetch: begin
                ctrl.MemReq    = 1'b1;
                ctrl.ALUSrcB   = 2'b10;
                ctrl.ResultSrc = 2'b10;
                ctrl.IRWrite   = ctrl.MemReady;
                ctrl.PCWrite   = ctrl.MemReady;
                if (ctrl.MemReady) w_next = StDecode;
            end
            StDecode: begin
                // ALU computes the branch target from OldPC + imm while the opcode decodes
                ctrl.ALUSrcA = 2'b01;
                ctrl.ALUSrcB = 2'b01;
                case (ctrl.Opcode)
                    OpLoad, OpStore: w_next = StMemAdr;
                    OpRType:         w_next = StExecR;
                    OpIType:         w_next = StExecI;
                    OpBranch:        w_next = StBeq;
                    OpJal:           w_next = StJal;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        w_next = StTrap;
`else
                        w_next         = StFetch;
                        ctrl.InstrDone = 1'b1;
`endif
                    end
                endcase
            end
            StMemAdr: begin
                ctrl.ALUSrcA = 2'b10;
                ctrl.ALUSrcB = 2'b01;
                w_next       = (ctrl.Opcode == OpLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                ctrl.MemReq = 1'b1;
                ctrl.AdrSrc = 1'b1;
                if (ctrl.MemReady) w_next = StMemWb;
            end
            StMemWrite: begin
                // Strobe stays up until the memory accepts the store
                ctrl.MemReq    = 1'b1;
                ctrl.AdrSrc    = 1'b1;
                ctrl.MemWrite  = 1'b1;
                ctrl.InstrDone = ctrl.MemReady;
                if (ctrl.MemReady) w_next = StFetch;
            end
            StMemWb: begin
                ctrl.ResultSrc = 2'b01;
                ctrl.RegWrite  = 1'b1;
                ctrl.InstrDone = 1'b1;
                w_next         = StFetch;
            end
            StExecR: begin
                ctrl.ALUSrcA = 2'b10;
                ctrl.ALUOp   = 2'b10;
                w_next       = StAluWb;
            end
            StExecI: begin
                ctrl.ALUSrcA = 2'b10;
                ctrl.ALUSrcB = 2'b01;
                ctrl.ALUOp   = 2'b11;
                w_next       = StAluWb;
            end
            StAluWb: begin
                ctrl.RegWrite  = 1'b1;
                ctrl.InstrDone = 1'b1;
                w_next         = StFetch;
            end
            StBeq: begin
                ctrl.ALUSrcA   = 2'b10;
                ctrl.ALUOp     = 2'b01;
                ctrl.PCWrite   = ctrl.Zero;
                ctrl.InstrDone = 1'b1;
                w_next         = StFetch;
            end
            StJal: begin
                // Link value PC+4 from OldPC + 4; PC takes the precomputed target
                ctrl.ALUSrcA = 2'b01;
                ctrl.ALUSrcB = 2'b10;
                ctrl.PCWrite = 1'b1;
                w_next       = StAluWb;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            StTrap: begin
                ctrl.IllegalInstr = 1'b1;
                w_next            = StTrap;
            end
`endif
            default: begin
                w_next = StFetch;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: per-cycle expected control vectors are
// queued by the stimulus process and compared by an independent monitor on the falling edge.
module tb_multicycle_main_control;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    exp_t sb[$];

    multicycle_main_control_if bus ();

    multicycle_main_control #(
        .RESET_STATE_FETCH(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ctrl (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {Ill, ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, MemReq, IRWrite, MemWrite, RegWrite,
    //  PCWrite, InstrDone}
    function automatic logic [15:0] pk(input logic ill, input logic [1:0] aluop,
                                       input logic [1:0] srca, input logic [1:0] srcb,
                                       input logic [1:0] res, input logic adr,
                                       input logic req, input logic irw, input logic mw,
                                       input logic rw, input logic pcw, input logic done);
        pk = {ill, aluop, srca, srcb, res, adr, req, irw, mw, rw, pcw, done};
    endfunction

    function automatic logic [15:0] v_fetch(input logic mr);
        v_fetch = pk(0, 2'b00, 2'b00, 2'b10, 2'b10, 0, 1, mr, 0, 0, mr, 0);
    endfunction
    function automatic logic [15:0] v_decode(input logic done);
        v_decode = pk(0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, done);
    endfunction
    function automatic logic [15:0] v_memadr();
        v_memadr = pk(0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] v_memread();
        v_memread = pk(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] v_memwrite(input logic mr);
        v_memwrite = pk(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0, 1, 0, 0, mr);
    endfunction
    function automatic logic [15:0] v_memwb();
        v_memwb = pk(0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 1, 0, 1);
    endfunction
    function automatic logic [15:0] v_execr();
        v_execr = pk(0, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] v_execi();
        v_execi = pk(0, 2'b11, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] v_aluwb();
        v_aluwb = pk(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1);
    endfunction
    function automatic logic [15:0] v_beq(input logic z);
        v_beq = pk(0, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, z, 1);
    endfunction
    function automatic logic [15:0] v_jal();
        v_jal = pk(0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 0, 1, 0);
    endfunction

    logic [15:0] w_act;
    always_comb begin
        w_act = {1'b0, bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc,
                 bus.MemReq, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.PCWrite,
                 bus.InstrDone};
`ifdef CTRL_ILLEGAL_TRAP_EN
        w_act[15] = bus.IllegalInstr;
`endif
    end

    // One cycle: drive inputs just after the rising edge, queue the expected outputs.
    task automatic cyc(input logic r, input logic [6:0] op, input logic z, input logic mr,
                       input logic [15:0] e, input string nm);
        exp_t item;
        @(posedge clk);
        #1;
        rst_n        = r;
        bus.Opcode   = op;
        bus.Zero     = z;
        bus.MemReady = mr;
        item.exp     = e;
        item.name    = nm;
        sb.push_back(item);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t item;
            item = sb.pop_front();
            checks++;
            if (w_act !== item.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", item.name, w_act, item.exp);
            end
        end
    end

    initial begin
        errors       = 0;
        checks       = 0;
        rst_n        = 1'b0;
        bus.Start    = 1'b0;
        bus.Opcode   = 7'd0;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b0;

        cyc(0, 7'd0, 0, 0, v_fetch(0), "reset_fetch0");
        cyc(0, 7'd0, 0, 1, v_fetch(1), "reset_fetch1");
        cyc(1, 7'd0, 0, 0, v_fetch(0), "release_fetch");

        // lw, MemReady high throughout
        cyc(1, OP_LW, 0, 1, v_fetch(1),  "lw_fetch");
        cyc(1, OP_LW, 0, 1, v_decode(0), "lw_decode");
        cyc(1, OP_LW, 0, 1, v_memadr(),  "lw_memadr");
        cyc(1, OP_LW, 0, 1, v_memread(), "lw_memread");
        cyc(1, OP_LW, 0, 1, v_memwb(),   "lw_memwb");

        // R-type
        cyc(1, OP_R, 0, 1, v_fetch(1),  "r_fetch");
        cyc(1, OP_R, 0, 1, v_decode(0), "r_decode");
        cyc(1, OP_R, 0, 1, v_execr(),   "r_execr");
        cyc(1, OP_R, 0, 1, v_aluwb(),   "r_aluwb");

        // I-type; opcode garbage after DECODE must not matter
        cyc(1, OP_I,   0, 1, v_fetch(1),  "i_fetch");
        cyc(1, OP_I,   0, 1, v_decode(0), "i_decode");
        cyc(1, OP_BAD, 0, 0, v_execi(),   "i_execi");
        cyc(1, OP_BAD, 0, 0, v_aluwb(),   "i_aluwb");

        // beq taken and not taken
        cyc(1, OP_BEQ, 1, 1, v_fetch(1),  "beq1_fetch");
        cyc(1, OP_BEQ, 1, 1, v_decode(0), "beq1_decode");
        cyc(1, OP_BEQ, 1, 1, v_beq(1),    "beq1_exec");
        cyc(1, OP_BEQ, 0, 1, v_fetch(1),  "beq0_fetch");
        cyc(1, OP_BEQ, 0, 1, v_decode(0), "beq0_decode");
        cyc(1, OP_BEQ, 0, 1, v_beq(0),    "beq0_exec");

        // jal
        cyc(1, OP_JAL, 0, 1, v_fetch(1),  "jal_fetch");
        cyc(1, OP_JAL, 0, 1, v_decode(0), "jal_decode");
        cyc(1, OP_JAL, 0, 1, v_jal(),     "jal_exec");
        cyc(1, OP_JAL, 0, 1, v_aluwb(),   "jal_aluwb");

        // sw with a fetch stall, MemReady ignored in DECODE/MEMADR, 3 store wait cycles
        cyc(1, OP_SW, 0, 0, v_fetch(0),     "sw_fetch_wait");
        cyc(1, OP_SW, 0, 1, v_fetch(1),     "sw_fetch");
        cyc(1, OP_SW, 0, 0, v_decode(0),    "sw_decode");
        cyc(1, OP_SW, 0, 0, v_memadr(),     "sw_memadr");
        cyc(1, OP_SW, 0, 0, v_memwrite(0),  "sw_wait1");
        cyc(1, OP_SW, 0, 0, v_memwrite(0),  "sw_wait2");
        cyc(1, OP_SW, 0, 0, v_memwrite(0),  "sw_wait3");
        cyc(1, OP_SW, 0, 1, v_memwrite(1),  "sw_done");
        cyc(1, OP_SW, 0, 0, v_fetch(0),     "sw_next_fetch");

        // Async reset landing in EXECR, then a normal R-type
        cyc(1, OP_R, 0, 1, v_fetch(1),  "rst_r_fetch");
        cyc(1, OP_R, 0, 1, v_decode(0), "rst_r_decode");
        cyc(0, OP_R, 0, 0, v_fetch(0),  "rst_in_execr");
        cyc(0, OP_R, 0, 0, v_fetch(0),  "rst_held");
        cyc(1, OP_R, 0, 0, v_fetch(0),  "rst_release");
        cyc(1, OP_R, 0, 1, v_fetch(1),  "post_rst_fetch");
        cyc(1, OP_R, 0, 1, v_decode(0), "post_rst_decode");
        cyc(1, OP_R, 0, 1, v_execr(),   "post_rst_execr");
        cyc(1, OP_R, 0, 1, v_aluwb(),   "post_rst_aluwb");

        // Unknown opcode
        cyc(1, OP_BAD, 0, 1, v_fetch(1), "bad_fetch");
`ifdef CTRL_ILLEGAL_TRAP_EN
        cyc(1, OP_BAD, 0, 1, v_decode(0), "bad_decode");
        cyc(1, OP_BAD, 0, 1, 16'h8000,    "trap1");
        cyc(1, OP_R,   1, 1, 16'h8000,    "trap2");
        cyc(0, OP_R,   0, 1, v_fetch(1),  "trap_reset");
        cyc(1, OP_R,   0, 0, v_fetch(0),  "trap_release");
`else
        cyc(1, OP_BAD, 0, 1, v_decode(1), "bad_decode_nop");
        cyc(1, OP_BAD, 0, 0, v_fetch(0),  "bad_next_fetch");
`endif

        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
